// File: rtl/mpu_host_pkg.sv
// Shared definitions for the MPU host-side controller: state encoding and default widths.
package mpu_host_pkg;
   localparam int MPU_DATA_W = 8;
   localparam int MPU_CNT_W  = 16;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_COOLDOWN
   } state_t;
endpackage

// File: rtl/mpu_host_timer.sv
// Loadable up-counter with synchronous clear, count enable and terminal-count compare.
module mpu_host_timer #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_tc_val,
   output logic             o_tc
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == i_tc_val);
endmodule

// File: rtl/mpu_host_interface.sv
// Host-side sequencer for the multicycle MPU: power-up reset, operand hand-off,
// result/timeout capture, and a cooldown reset between jobs.
module mpu_host_interface
   import mpu_host_pkg::*;
#(
   parameter int DATA_W          = MPU_DATA_W,
   parameter int START_DELAY     = 2,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int COOLDOWN_CYCLES = 4,
   parameter int CNT_W           = MPU_CNT_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_host_in_valid,
   input  logic [DATA_W-1:0] i_host_in_data,
   output logic              o_host_in_ready,
   output logic              o_mpu_reset,
   output logic              o_mpu_start,
   output logic [DATA_W-1:0] o_mpu_in,
   input  logic [DATA_W-1:0] i_mpu_out,
   output logic              o_result_valid,
   output logic [DATA_W-1:0] o_result_data,
   input  logic              i_result_ack,
   output logic              o_timeout,
   output logic              o_busy,
   output state_t            o_state
);
   // Host port: an operand transfers on any edge where valid and ready are both
   // high; ready is only asserted in IDLE. Result port: result_valid holds with
   // data/timeout until an edge with result_ack high.
   state_t            r_state, w_nxt_state;
   logic              r_mpu_reset, w_nxt_mpu_reset;
   logic              r_mpu_start, w_nxt_mpu_start;
   logic [DATA_W-1:0] r_mpu_in, w_nxt_mpu_in;
   logic              r_result_valid, w_nxt_result_valid;
   logic [DATA_W-1:0] r_result_data, w_nxt_result_data;
   logic              r_timeout, w_nxt_timeout;
   logic              w_tmr_clr, w_tmr_en, w_tmr_tc;
   logic [CNT_W-1:0]  w_tc_val;

   mpu_host_timer #(.CNT_W(CNT_W)) u_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_tmr_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_en       (w_tmr_en),
      .i_tc_val   (w_tc_val),
      .o_tc       (w_tmr_tc)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_POWERUP;
         r_mpu_reset    <= 1'b1;
         r_mpu_start    <= 1'b0;
         r_mpu_in       <= '0;
         r_result_valid <= 1'b0;
         r_result_data  <= '0;
         r_timeout      <= 1'b0;
      end else begin
         r_state        <= w_nxt_state;
         r_mpu_reset    <= w_nxt_mpu_reset;
         r_mpu_start    <= w_nxt_mpu_start;
         r_mpu_in       <= w_nxt_mpu_in;
         r_result_valid <= w_nxt_result_valid;
         r_result_data  <= w_nxt_result_data;
         r_timeout      <= w_nxt_timeout;
      end
   end

   always_comb begin
      w_nxt_state        = r_state;
      w_nxt_mpu_reset    = r_mpu_reset;
      w_nxt_mpu_start    = r_mpu_start;
      w_nxt_mpu_in       = r_mpu_in;
      w_nxt_result_valid = r_result_valid;
      w_nxt_result_data  = r_result_data;
      w_nxt_timeout      = r_timeout;
      w_tmr_clr          = 1'b0;
      w_tmr_en           = 1'b0;
      w_tc_val           = '0;
      case (r_state)
         ST_POWERUP: begin
            w_tc_val = CNT_W'(START_DELAY - 1);
            if (w_tmr_tc) begin
               w_nxt_state     = ST_IDLE;
               w_nxt_mpu_reset = 1'b0;
               w_tmr_clr       = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_IDLE: begin
            if (i_host_in_valid) begin
               w_nxt_mpu_in    = i_host_in_data;
               w_nxt_timeout   = 1'b0;
               w_nxt_mpu_start = 1'b1;
               w_nxt_state     = ST_RUN;
               w_tmr_clr       = 1'b1;
            end
         end
         ST_RUN: begin
            // A result arriving on the timeout edge still counts as a result.
            w_tc_val = CNT_W'(TIMEOUT_CYCLES - 1);
            if (i_mpu_out != '0) begin
               w_nxt_result_data  = i_mpu_out;
               w_nxt_result_valid = 1'b1;
               w_nxt_timeout      = 1'b0;
               w_nxt_mpu_start    = 1'b0;
               w_nxt_state        = ST_DONE;
            end else if (w_tmr_tc) begin
               w_nxt_result_data  = '0;
               w_nxt_result_valid = 1'b1;
               w_nxt_timeout      = 1'b1;
               w_nxt_mpu_start    = 1'b0;
               w_nxt_state        = ST_DONE;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_DONE: begin
            if (i_result_ack) begin
               w_nxt_result_valid = 1'b0;
               w_nxt_mpu_reset    = 1'b1;
               w_nxt_state        = ST_COOLDOWN;
               w_tmr_clr          = 1'b1;
            end
         end
         ST_COOLDOWN: begin
            w_tc_val = CNT_W'(COOLDOWN_CYCLES - 1);
            if (w_tmr_tc) begin
               w_nxt_mpu_reset = 1'b0;
               w_nxt_state     = ST_IDLE;
               w_tmr_clr       = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         default: begin
            w_nxt_state = ST_POWERUP;
         end
      endcase
   end

   assign o_host_in_ready = (r_state == ST_IDLE);
   assign o_busy          = (r_state != ST_IDLE);
   assign o_state         = r_state;
   assign o_mpu_reset     = r_mpu_reset;
   assign o_mpu_start     = r_mpu_start;
   assign o_mpu_in        = r_mpu_in;
   assign o_result_valid  = r_result_valid;
   assign o_result_data   = r_result_data;
   assign o_timeout       = r_timeout;
endmodule

// File: tb/tb_mpu_host_interface.sv
// Directed-plus-random bench for mpu_host_interface; the bench plays both host and MPU.
module tb_mpu_host_interface;
   import mpu_host_pkg::*;

   localparam int DW = 8;
   localparam int SD = 2;
   localparam int TO = 16;
   localparam int CD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_in_valid;
   logic [DW-1:0] host_in_data;
   logic          host_in_ready;
   logic          mpu_reset;
   logic          mpu_start;
   logic [DW-1:0] mpu_in;
   logic [DW-1:0] mpu_out;
   logic          result_valid;
   logic [DW-1:0] result_data;
   logic          result_ack;
   logic          timeout;
   logic          busy;
   state_t        dbg_state;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mpu_host_interface #(
      .DATA_W(DW), .START_DELAY(SD), .TIMEOUT_CYCLES(TO),
      .COOLDOWN_CYCLES(CD), .CNT_W(16)
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_host_in_valid (host_in_valid),
      .i_host_in_data  (host_in_data),
      .o_host_in_ready (host_in_ready),
      .o_mpu_reset     (mpu_reset),
      .o_mpu_start     (mpu_start),
      .o_mpu_in        (mpu_in),
      .i_mpu_out       (mpu_out),
      .o_result_valid  (result_valid),
      .o_result_data   (result_data),
      .i_result_ack    (result_ack),
      .o_timeout       (timeout),
      .o_busy          (busy),
      .o_state         (dbg_state)
   );

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: the MPU answers after lat idle cycles; the job ends on the
   // answer cycle, or after TO RUN cycles if the answer comes too late.
   function automatic int ref_run_cycles(input int lat);
      return (lat < TO) ? lat + 1 : TO;
   endfunction

   function automatic logic ref_timeout(input int lat);
      return (lat >= TO);
   endfunction

   // Called at the first sample point after reset is released.
   task automatic check_powerup(input string tag);
      for (int k = 0; k <= SD; k++) begin
         chk1({tag, "_mpu_reset"}, mpu_reset, (k < SD));
         chk1({tag, "_ready"}, host_in_ready, (k == SD));
         chk1({tag, "_no_result"}, result_valid, 1'b0);
         if (k < SD) wait_clk();
      end
   endtask

   task automatic run_job(input logic [DW-1:0] op, input int lat,
                          input logic [DW-1:0] val, input int ack_dly);
      int            n_run;
      logic [DW-1:0] e_data;
      logic          e_to;
      n_run  = ref_run_cycles(lat);
      e_to   = ref_timeout(lat);
      e_data = e_to ? '0 : val;

      chk1("idle_ready", host_in_ready, 1'b1);
      host_in_valid = 1'b1;
      host_in_data  = op;
      mpu_out       = '0;
      wait_clk();
      host_in_valid = 1'b0;
      host_in_data  = DW'($urandom);

      for (int c = 1; c <= n_run; c++) begin
         chk1("run_start", mpu_start, 1'b1);
         chk8("run_mpu_in", mpu_in, op);
         chk1("run_no_result", result_valid, 1'b0);
         chk1("run_ready", host_in_ready, 1'b0);
         mpu_out    = (c > lat) ? val : '0;
         result_ack = 1'($urandom_range(0, 1));
         wait_clk();
      end
      result_ack = 1'b0;

      chk1("done_valid", result_valid, 1'b1);
      chk8("done_data", result_data, e_data);
      chk1("done_timeout", timeout, e_to);
      chk1("done_start_low", mpu_start, 1'b0);
      chk8("done_mpu_in", mpu_in, op);
      chk1("done_busy", busy, 1'b1);

      for (int d = 0; d < ack_dly; d++) begin
         wait_clk();
         chk1("hold_valid", result_valid, 1'b1);
         chk8("hold_data", result_data, e_data);
         chk1("hold_timeout", timeout, e_to);
         chk1("hold_ready", host_in_ready, 1'b0);
      end

      result_ack = 1'b1;
      wait_clk();
      result_ack = 1'b0;
      chk1("ack_valid_low", result_valid, 1'b0);
      // MPU model: its output bus clears once it sees reset.
      if (mpu_reset) mpu_out = '0;
      for (int k = 1; k <= CD; k++) begin
         chk1("cool_mpu_reset", mpu_reset, 1'b1);
         chk1("cool_ready", host_in_ready, 1'b0);
         wait_clk();
      end
      chk1("post_ready", host_in_ready, 1'b1);
      chk1("post_mpu_reset", mpu_reset, 1'b0);
      chk8("post_mpu_in", mpu_in, op);
   endtask

   initial begin
      reset         = 1'b1;
      host_in_valid = 1'b0;
      host_in_data  = '0;
      mpu_out       = '0;
      result_ack    = 1'b0;

      // Reset held three cycles.
      for (int k = 0; k < 3; k++) begin
         wait_clk();
         chk1("rst_mpu_reset", mpu_reset, 1'b1);
         chk1("rst_mpu_start", mpu_start, 1'b0);
         chk1("rst_ready", host_in_ready, 1'b0);
         chk1("rst_busy", busy, 1'b1);
         chk1("rst_valid", result_valid, 1'b0);
         chk8("rst_data", result_data, '0);
         chk1("rst_timeout", timeout, 1'b0);
         chk8("rst_mpu_in", mpu_in, '0);
      end
      reset = 1'b0;
      check_powerup("pwr");

      // Directed: answer after 10 idle cycles, held 20 cycles before ack.
      run_job(8'h05, 10, 8'h2A, 20);
      // Pure timeout.
      run_job(8'h3C, 16, 8'h77, 2);
      // Late timeout far beyond the limit.
      run_job(8'hC3, 40, 8'h11, 0);
      // Answer on the final RUN cycle beats the timeout.
      run_job(8'h9E, 15, 8'h01, 1);
      // Immediate answer.
      run_job(8'h00, 0, 8'hFF, 3);

      for (int j = 0; j < 8; j++) begin
         run_job(DW'($urandom), $urandom_range(0, 20),
                 DW'($urandom_range(1, 255)), $urandom_range(0, 5));
      end

      // Reset in the middle of a job: no result for it.
      host_in_valid = 1'b1;
      host_in_data  = 8'h6B;
      wait_clk();
      host_in_valid = 1'b0;
      for (int c = 0; c < 3; c++) wait_clk();
      chk1("mid_start", mpu_start, 1'b1);
      mpu_out = 8'h55;
      reset   = 1'b1;
      wait_clk();
      chk1("abort_start", mpu_start, 1'b0);
      chk1("abort_mpu_reset", mpu_reset, 1'b1);
      chk1("abort_valid", result_valid, 1'b0);
      chk1("abort_ready", host_in_ready, 1'b0);
      chk8("abort_mpu_in", mpu_in, '0);
      mpu_out = '0;
      reset   = 1'b0;
      check_powerup("repwr");
      run_job(8'hA1, 5, 8'h42, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
